// File: rtl/sseg_scan_decoder.sv
// Recovers the digits shown on a multiplexed 8-digit 7-segment scan: one capture per dwell, atomic frame commit.
// Optional frame-stability flag enabled by defining SSEG_STABLE_CHECK_EN.
module sseg_scan_decoder #(
  parameter int unsigned SETTLE        = 4,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sseg_an,
  input  logic [7:0]  sseg_ca,
  output logic [63:0] dig_raw,
  output logic [31:0] dig_hex,
  output logic [7:0]  dig_valid,
  output logic [7:0]  dig_blank,
  output logic        frame_stb,
  output logic        an_err,
  output logic [7:0]  err_cnt,
  output logic        stable
);

  localparam int unsigned NDIG = 8;
  // one counter width serves both the settle count and the frame-match count
  localparam int unsigned CMAX = (SETTLE > STABLE_FRAMES) ? SETTLE : STABLE_FRAMES;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned RW   = CW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HELD   = 2'd2;

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [7:0]    an_q, ca_q, an_p, ca_p;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] run;
  logic          capture;
  logic [2:0]    idx;
  logic [7:0]    cap_bit;
  logic          an_legal, an_illegal, same;
  logic [7:0]    mask;
  logic [7:0]    shadow [NDIG];
  logic [63:0]   shadow_flat;
  logic [31:0]   hex_c;
  logic [7:0]    valid_c, blank_c;
  logic          in_ill, err_pend, commit, ill_first, err_evt;

  // anode classification of the registered sample
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!an_q[i]) idx = 3'(7 - i);
    end
    an_legal   = ($countones(~an_q) == 1);
    an_illegal = !an_legal && (an_q != 8'hFF);
    same       = (an_q == an_p) && (ca_q == ca_p);
    cap_bit    = 8'h01 << idx;
  end

  assign commit    = (mask == 8'hFF);
  assign ill_first = an_illegal && !in_ill;
  // an error coinciding with a full mask waits one cycle so the commit lands first
  assign err_evt   = (ill_first && !commit) || err_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // dwell tracking: run counts identical legal samples, capture once when it reaches SETTLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    run       = '0;
    if (!an_legal) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else if (!(state == S_HELD && same)) begin
      run = (state == S_SETTLE && same) ? RW'(cnt) + RW'(1) : RW'(1);
      if (run >= RW'(SETTLE)) begin
        capture   = 1'b1;
        state_nxt = S_HELD;
      end else begin
        state_nxt = S_SETTLE;
      end
      cnt_nxt = CW'(run);
    end
  end

  // glyph decode of the shadow slots, applied at commit
  always_comb begin
    shadow_flat = '0;
    hex_c       = '0;
    valid_c     = '0;
    blank_c     = '0;
    for (int n = 0; n < NDIG; n++) begin
      shadow_flat[8*n +: 8] = shadow[n];
      if (shadow[n] == 8'hFF) begin
        blank_c[n] = 1'b1;
      end else begin
        for (int h = 0; h < 16; h++) begin
          if (shadow[n][6:0] == GLYPH[h]) begin
            valid_c[n]       = 1'b1;
            hex_c[4*n +: 4]  = 4'(h);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q      <= 8'hFF;
      ca_q      <= 8'hFF;
      an_p      <= 8'hFF;
      ca_p      <= 8'hFF;
      in_ill    <= 1'b0;
      err_pend  <= 1'b0;
      mask      <= '0;
      for (int n = 0; n < NDIG; n++) shadow[n] <= 8'hFF;
      dig_raw   <= '1;
      dig_hex   <= '0;
      dig_valid <= '0;
      dig_blank <= 8'hFF;
      frame_stb <= 1'b0;
      an_err    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      an_q      <= sseg_an;
      ca_q      <= sseg_ca;
      an_p      <= an_q;
      ca_p      <= ca_q;
      in_ill    <= an_illegal;
      err_pend  <= ill_first && commit;
      frame_stb <= commit;
      an_err    <= err_evt;
      if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (capture) shadow[idx] <= ca_q;
      if (commit || err_evt) mask <= capture ? cap_bit : 8'h00;
      else if (capture)      mask <= mask | cap_bit;
      if (commit) begin
        dig_raw   <= shadow_flat;
        dig_hex   <= hex_c;
        dig_valid <= valid_c;
        dig_blank <= blank_c;
      end
    end
  end

`ifdef SSEG_STABLE_CHECK_EN
  logic [CW-1:0] frm_cnt;
  logic [RW-1:0] frm_run;

  // consecutive identical committed frames, saturating
  always_comb begin
    frm_run = RW'(1);
    if (frm_cnt != '0 && shadow_flat == dig_raw)
      frm_run = (frm_cnt == '1) ? RW'(frm_cnt) : RW'(frm_cnt) + RW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt <= '0;
      stable  <= 1'b0;
    end else if (err_evt) begin
      frm_cnt <= '0;
      stable  <= 1'b0;
    end else if (commit) begin
      frm_cnt <= CW'(frm_run);
      stable  <= (frm_run >= RW'(STABLE_FRAMES));
    end
  end
`else
  assign stable = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Randomized and directed bench for sseg_scan_decoder against a dwell-level reference model.
module tb_sseg_scan_decoder;

  localparam int unsigned SETTLE        = 4;
  localparam int unsigned STABLE_FRAMES = 3;
`ifdef SSEG_STABLE_CHECK_EN
  localparam bit STAB_EN = 1'b1;
`else
  localparam bit STAB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sseg_an = 8'hFF;
  logic [7:0]  sseg_ca = 8'hFF;
  logic [63:0] dig_raw;
  logic [31:0] dig_hex;
  logic [7:0]  dig_valid, dig_blank, err_cnt;
  logic        frame_stb, an_err, stable;

  always #5 clk = ~clk;

  sseg_scan_decoder #(.SETTLE(SETTLE), .STABLE_FRAMES(STABLE_FRAMES)) dut (
    .clk(clk), .rst(rst), .sseg_an(sseg_an), .sseg_ca(sseg_ca),
    .dig_raw(dig_raw), .dig_hex(dig_hex), .dig_valid(dig_valid), .dig_blank(dig_blank),
    .frame_stb(frame_stb), .an_err(an_err), .err_cnt(err_cnt), .stable(stable)
  );

  typedef struct packed {
    logic [63:0] raw;
    logic [31:0] hex;
    logic [7:0]  valid;
    logic [7:0]  blank;
    logic        stab;
  } frame_t;

  frame_t exp_q[$];
  frame_t obs_q[$];
  frame_t mon_f, fo, fe;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     obs_errs = 0;
  longint cyc = 0, last_frame_cyc = 0, last_err_cyc = 0;

  // reference model state
  logic [7:0][7:0] m_shadow;
  logic [7:0]      m_mask, m_an, m_ca, m_errcnt;
  logic [63:0]     m_last_raw;
  bit              m_prev_legal, m_prev_ill;
  int              m_run, m_same, m_errs;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (frame_stb) begin
        mon_f.raw = dig_raw; mon_f.hex = dig_hex; mon_f.valid = dig_valid;
        mon_f.blank = dig_blank; mon_f.stab = stable;
        obs_q.push_back(mon_f);
        last_frame_cyc = cyc;
      end
      if (an_err) begin
        obs_errs++;
        last_err_cyc = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] glyph(input int h);
    logic [6:0] g;
    case (h)
      0: g = 7'h40;  1: g = 7'h79;  2: g = 7'h24;  3: g = 7'h30;
      4: g = 7'h19;  5: g = 7'h12;  6: g = 7'h02;  7: g = 7'h78;
      8: g = 7'h00;  9: g = 7'h10; 10: g = 7'h08; 11: g = 7'h03;
      12: g = 7'h46; 13: g = 7'h21; 14: g = 7'h06; 15: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return {1'b1, g};
  endfunction

  function automatic logic [7:0] an_of(input int n);
    return 8'hFF ^ (8'h80 >> n);
  endfunction

  task automatic model_reset();
    m_shadow = '1; m_mask = '0; m_an = 8'hFF; m_ca = 8'hFF; m_errcnt = '0;
    m_last_raw = '1; m_prev_legal = 0; m_prev_ill = 0; m_run = 0; m_same = 0; m_errs = 0;
    exp_q.delete();
  endtask

  task automatic model_commit();
    frame_t     f;
    logic [7:0] g;
    f.raw = m_shadow; f.hex = '0; f.valid = '0; f.blank = '0;
    for (int n = 0; n < 8; n++) begin
      if (m_shadow[n] == 8'hFF) f.blank[n] = 1'b1;
      else for (int h = 0; h < 16; h++) begin
        g = glyph(h);
        if (m_shadow[n][6:0] == g[6:0]) begin f.valid[n] = 1'b1; f.hex[4*n +: 4] = 4'(h); end
      end
    end
    m_same = (m_same != 0 && f.raw == m_last_raw) ? m_same + 1 : 1;
    m_last_raw = f.raw;
    f.stab = STAB_EN && (m_same >= int'(STABLE_FRAMES));
    exp_q.push_back(f);
  endtask

  // apply one (an, ca) pair for len cycles and advance the model by the same dwell
  task automatic dwell(input logic [7:0] an, input logic [7:0] ca, input int len);
    bit legal, ill;
    int idx;
    legal = ($countones(~an) == 1);
    ill   = !legal && (an != 8'hFF);
    idx   = 0;
    if (legal) begin
      m_run = (m_prev_legal && an == m_an && ca == m_ca) ? m_run + len : len;
      if (m_run >= int'(SETTLE) && m_run - len < int'(SETTLE)) begin
        for (int i = 0; i < 8; i++) if (!an[i]) idx = 7 - i;
        m_shadow[idx] = ca;
        m_mask[idx]   = 1'b1;
        if (m_mask == 8'hFF) begin model_commit(); m_mask = '0; end
      end
    end else begin
      m_run = 0;
    end
    if (ill && !m_prev_ill) begin
      m_errs++;
      if (m_errcnt != 8'hFF) m_errcnt++;
      m_mask = '0;
      m_same = 0;
    end
    m_prev_legal = legal; m_prev_ill = ill; m_an = an; m_ca = ca;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      sseg_an = an;
      sseg_ca = ca;
    end
  endtask

  task automatic scan(input logic [7:0][7:0] d, input int first, input int last, input int len);
    for (int n = first; n <= last; n++) dwell(an_of(n), d[n], len);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sseg_an = 8'hFF; sseg_ca = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (dig_raw !== '1)      begin n_fail++; $display("FAIL reset_raw: got %h want all FF", dig_raw); end
    n_checks++; if (dig_hex !== 32'h0)   begin n_fail++; $display("FAIL reset_hex: got %h want 0", dig_hex); end
    n_checks++; if (dig_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid: got %h want 00", dig_valid); end
    n_checks++; if (dig_blank !== 8'hFF) begin n_fail++; $display("FAIL reset_blank: got %h want FF", dig_blank); end
    n_checks++; if (frame_stb !== 1'b0)  begin n_fail++; $display("FAIL reset_stb: got %b want 0", frame_stb); end
    n_checks++; if (an_err !== 1'b0)     begin n_fail++; $display("FAIL reset_anerr: got %b want 0", an_err); end
    n_checks++; if (err_cnt !== 8'h00)   begin n_fail++; $display("FAIL reset_errcnt: got %h want 00", err_cnt); end
    n_checks++; if (stable !== 1'b0)     begin n_fail++; $display("FAIL reset_stable: got %b want 0", stable); end
  endtask

  task automatic test_scan_hex();
    logic [7:0][7:0] d;
    int v[8] = '{1, 2, 3, 4, 10, 11, 12, 13};
    for (int n = 0; n < 8; n++) d[n] = glyph(v[n]);
    scan(d, 0, 6, 10);
    repeat (4) @(negedge clk);
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL scan_early: got %0d frames, want 0", obs_q.size()); end
    scan(d, 7, 7, 10);
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL scan_count: got %0d frames, want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0].hex !== 32'hDCBA4321) begin n_fail++; $display("FAIL scan_hex: got %h want DCBA4321", obs_q[0].hex); end
      n_checks++; if (obs_q[0].valid !== 8'hFF) begin n_fail++; $display("FAIL scan_valid: got %h want FF", obs_q[0].valid); end
      n_checks++; if (obs_q[0].blank !== 8'h00) begin n_fail++; $display("FAIL scan_blank: got %h want 00", obs_q[0].blank); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      fo = obs_q.pop_front(); fe = exp_q.pop_front();
      n_checks++; if (fo !== fe) begin n_fail++; $display("FAIL scan_model: got %h want %h", fo, fe); end
    end
  endtask

  task automatic test_blank();
    logic [7:0][7:0] d;
    for (int n = 0; n < 4; n++) d[n] = 8'hFF;
    d[4] = glyph(15); d[5] = glyph(0); d[6] = glyph(0); d[7] = glyph(0);
    scan(d, 0, 7, 7);
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL blank_count: got %0d frames, want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0].blank !== 8'h0F) begin n_fail++; $display("FAIL blank_blank: got %h want 0F", obs_q[0].blank); end
      n_checks++; if (obs_q[0].valid !== 8'hF0) begin n_fail++; $display("FAIL blank_valid: got %h want F0", obs_q[0].valid); end
      n_checks++; if (obs_q[0].hex[31:16] !== 16'h000F) begin n_fail++; $display("FAIL blank_hex: got %h want 000F", obs_q[0].hex[31:16]); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      fo = obs_q.pop_front(); fe = exp_q.pop_front();
      n_checks++; if (fo !== fe) begin n_fail++; $display("FAIL blank_model: got %h want %h", fo, fe); end
    end
  endtask

  task automatic test_dwell();
    logic [7:0][7:0] d;
    for (int n = 0; n < 8; n++) d[n] = glyph(n + 5);
    scan(d, 0, 7, 3);
    scan(d, 0, 7, 3);
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL dwell3_frames: got %0d, want 0", obs_q.size()); end
    scan(d, 0, 7, 4);
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL dwell4_frames: got %0d, want 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      fo = obs_q.pop_front(); fe = exp_q.pop_front();
      n_checks++; if (fo !== fe) begin n_fail++; $display("FAIL dwell_model: got %h want %h", fo, fe); end
    end
  endtask

  task automatic test_illegal();
    logic [7:0][7:0] d;
    int e0;
    e0 = obs_errs;
    for (int n = 0; n < 8; n++) d[n] = glyph(15 - n);
    scan(d, 0, 3, 6);
    dwell(8'b00111111, d[3], 5);
    scan(d, 4, 7, 6);
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_errs - e0 != 1) begin n_fail++; $display("FAIL illegal_pulses: got %0d, want 1", obs_errs - e0); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL illegal_errcnt: got %0d want 1", err_cnt); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL illegal_partial: got %0d frames, want 0", obs_q.size()); end
    scan(d, 0, 7, 6);
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL illegal_next: got %0d frames, want 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      fo = obs_q.pop_front(); fe = exp_q.pop_front();
      n_checks++; if (fo !== fe) begin n_fail++; $display("FAIL illegal_model: got %h want %h", fo, fe); end
    end
  endtask

  task automatic test_commit_err();
    logic [7:0][7:0] d;
    int e0;
    for (int n = 0; n < 8; n++) d[n] = glyph(n);
    dwell(8'h00, 8'hFF, 2);
    dwell(8'hFF, 8'hFF, 4);
    e0 = obs_errs;
    scan(d, 0, 7, 4);
    dwell(8'b11100111, 8'hFF, 3);
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_errs - e0 != 1) begin n_fail++; $display("FAIL cerr_pulses: got %0d, want 1", obs_errs - e0); end
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL cerr_frames: got %0d, want 1", obs_q.size()); end
    n_checks++; if (last_err_cyc <= last_frame_cyc) begin n_fail++; $display("FAIL cerr_order: err cycle %0d, frame cycle %0d, want err later", last_err_cyc, last_frame_cyc); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      fo = obs_q.pop_front(); fe = exp_q.pop_front();
      n_checks++; if (fo !== fe) begin n_fail++; $display("FAIL cerr_model: got %h want %h", fo, fe); end
    end
  endtask

  task automatic test_stable();
    logic [7:0][7:0] a, b;
    bit want[7] = '{0, 0, 1, 0, 0, 0, 1};
    int k;
    for (int n = 0; n < 8; n++) begin a[n] = glyph(n + 1); b[n] = glyph(n + 1); end
    b[5] = glyph(14);
    dwell(8'h7E, 8'hFF, 2);
    dwell(8'hFF, 8'hFF, 4);
    for (int r = 0; r < 3; r++) scan(a, 0, 7, 5);
    dwell(8'hFF, 8'hFF, 6);
    n_checks++; if (stable !== STAB_EN) begin n_fail++; $display("FAIL stable_set: got %b want %b", stable, STAB_EN); end
    scan(b, 0, 7, 5);
    for (int r = 0; r < 3; r++) scan(a, 0, 7, 5);
    dwell(8'hFF, 8'hFF, 6);
    n_checks++; if (stable !== STAB_EN) begin n_fail++; $display("FAIL stable_reset: got %b want %b", stable, STAB_EN); end
    dwell(8'h5F, 8'hFF, 2);
    dwell(8'hFF, 8'hFF, 6);
    n_checks++; if (stable !== 1'b0) begin n_fail++; $display("FAIL stable_err: got %b want 0", stable); end
    n_checks++; if (obs_q.size() != 7) begin n_fail++; $display("FAIL stable_frames: got %0d, want 7", obs_q.size()); end
    k = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      fo = obs_q.pop_front(); fe = exp_q.pop_front();
      n_checks++; if (fo.stab !== (STAB_EN && want[k])) begin n_fail++; $display("FAIL stable_frame%0d: got %b want %b", k, fo.stab, STAB_EN && want[k]); end
      n_checks++; if (fo !== fe) begin n_fail++; $display("FAIL stable_model: got %h want %h", fo, fe); end
      if (k < 6) k++;
    end
  endtask

  task automatic test_random();
    logic [7:0] an, ca;
    int r, a, b, e0, nf;
    e0 = obs_errs; nf = 0;
    for (int t = 0; t < 600; t++) begin
      r = int'($urandom_range(0, 63));
      if (r == 0) begin
        a = int'($urandom_range(0, 7));
        b = (a + 1 + int'($urandom_range(0, 6))) % 8;
        an = 8'hFF; an[a] = 1'b0; an[b] = 1'b0;
      end else if (r < 5) an = 8'hFF;
      else an = an_of(int'($urandom_range(0, 7)));
      case ($urandom_range(0, 3))
        0: ca = glyph(int'($urandom_range(0, 15)));
        1: ca = glyph(int'($urandom_range(0, 15))) & 8'h7F;
        2: ca = 8'($urandom);
        default: ca = 8'hFF;
      endcase
      dwell(an, ca, int'($urandom_range(1, 8)));
    end
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_frames: got %0d, want %0d", obs_q.size(), exp_q.size()); end
    n_checks++; if (obs_errs - e0 != m_errs - 0 - (e0 - 0) + (e0 - e0) && 0) begin n_fail++; end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      fo = obs_q.pop_front(); fe = exp_q.pop_front(); nf++;
      n_checks++; if (fo !== fe) begin n_fail++; $display("FAIL rand_frame%0d: got %h want %h", nf, fo, fe); end
    end
    n_checks++; if (err_cnt !== m_errcnt) begin n_fail++; $display("FAIL rand_errcnt: got %0d want %0d", err_cnt, m_errcnt); end
    n_checks++; if (obs_errs !== m_errs) begin n_fail++; $display("FAIL rand_pulses: got %0d want %0d", obs_errs, m_errs); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0][7:0] d;
    for (int n = 0; n < 8; n++) d[n] = glyph(9 - n);
    scan(d, 0, 3, 5);
    do_reset();
    obs_errs = 0;
    n_checks++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL mid_errcnt: got %h want 00", err_cnt); end
    n_checks++; if (dig_raw !== '1) begin n_fail++; $display("FAIL mid_raw: got %h want all FF", dig_raw); end
    scan(d, 4, 7, 5);
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_partial: got %0d frames, want 0", obs_q.size()); end
    scan(d, 0, 3, 5);
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL mid_frames: got %0d, want 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      fo = obs_q.pop_front(); fe = exp_q.pop_front();
      n_checks++; if (fo !== fe) begin n_fail++; $display("FAIL mid_model: got %h want %h", fo, fe); end
    end
  endtask

  task automatic test_saturation();
    int e0;
    e0 = obs_errs;
    for (int t = 0; t < 300; t++) begin
      dwell(8'h00, 8'h00, 1);
      dwell(8'hFF, 8'hFF, 1);
    end
    dwell(8'hFF, 8'hFF, 8);
    n_checks++; if (obs_errs - e0 != 300) begin n_fail++; $display("FAIL sat_pulses: got %0d, want 300", obs_errs - e0); end
    n_checks++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_errcnt: got %h want FF", err_cnt); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan_hex();
    test_blank();
    test_dwell();
    test_illegal();
    test_commit_err();
    test_stable();
    test_random();
    test_reset_midframe();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
